control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock for all flops.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 scan_in0  input  1  serial scan data into the single scan chain.
REQ-005 scan_en  input  1  1 = scan shift mode, 0 = functional mode.
REQ-006 scan_out0  output  1  serial scan data out, driven directly by the last chain flop.
REQ-007 The block SHALL have no other ports.

Function
REQ-008 The block SHALL hold these registers:
  - state[1:0]: IDLE=0, LOAD=1, CALC=2, STORE=3
  - bit_cnt[4:0]
  - ch_cnt[4:0]
  - frame_cnt[7:0]
  - 20 flops in total.
REQ-009 The scan chain vector SHALL be C[19:0] = {state[1:0], bit_cnt[4:0], ch_cnt[4:0], frame_cnt[7:0]}.
REQ-010 scan_out0 SHALL equal C[19] (state[1]) in both modes.
REQ-011 With scan_en=1 and reset=0, each clock SHALL perform C <= {C[18:0], scan_in0}, with no functional update.
REQ-012 With scan_en=0 and reset=0, the state machine SHALL advance once per clock per REQ-013..REQ-017.
REQ-013 IDLE: next state LOAD; all counters hold.
REQ-014 LOAD: next state CALC; bit_cnt <= 0.
REQ-015 CALC:
  - bit_cnt increments by 1 each cycle.
  - When bit_cnt >= 15, next state is STORE and bit_cnt <= 0.
  - Result: exactly 16 CALC cycles per channel from a LOAD entry.
REQ-016 STORE: next state LOAD; ch_cnt increments.
  - When ch_cnt >= 23, ch_cnt <= 0 and frame_cnt increments.
  - frame_cnt wraps modulo 256 (255 -> 0).
REQ-017 Channel period SHALL be 18 cycles (LOAD + 16 CALC + STORE); frame period SHALL be 24 x 18 = 432 cycles.
REQ-018 Out-of-range values loaded by scan SHALL recover as follows:
  - bit_cnt >= 15 in CALC goes to STORE next cycle.
  - ch_cnt >= 23 in STORE wraps to 0 with a frame_cnt increment.
REQ-019 Counters not named in the current state's rule SHALL hold their value.

Reset
REQ-020 When reset=1 at a clock edge, all 20 flops SHALL clear to 0 (state IDLE), regardless of scan_en; reset has priority over shift.
REQ-021 After reset, scan_out0 SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL clear all flops on that edge, with no partial update.
REQ-023 The first functional edge after reset deassertion SHALL move IDLE to LOAD.

Structure
REQ-024 State encodings, CALC_LAST=15, CH_LAST=23 and CHAIN_LEN=20 SHALL live in a shared package used by RTL and bench.
REQ-025 The design SHALL be one module with no sub-modules.
REQ-026 The scan mux SHALL be in RTL ahead of each flop, so that C[19:0] is one register vector with separate shift and functional next-state logic.

Verification
REQ-027 Reset then one functional clock, then shift 20 cycles: scan_out0 sequence (MSB first) = 0,1 followed by eighteen 0s.
REQ-028 Loopback: shift in 0xA5C3F (20 bits, MSB first) with scan_en=1, then 20 more shifts with scan_in0=0 -> scan_out0 returns 0xA5C3F MSB first.
REQ-029 Scan-load state=STORE, ch_cnt=23, frame_cnt=255, then one functional clock, then unload -> state=LOAD, ch_cnt=0, frame_cnt=0, bit_cnt unchanged.
REQ-030 From reset, run 433 functional clocks, then unload -> state=LOAD, bit_cnt=0, ch_cnt=0, frame_cnt=1.
REQ-031 Scan-load state=CALC, bit_cnt=20, then one functional clock -> state=STORE, bit_cnt=0.
REQ-032 Assert reset while scan_en=1 with a nonzero chain -> all 20 flops read back 0.

Source files
------------

// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared encodings and limits for the control unit
// Purpose: state encoding, counter limits and scan chain length used by the
//          control unit RTL and its testbench.
// Ports:   none (package).
package control_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CALC  = 2'd2,
    STORE = 2'd3
  } state_e;

  // Last CALC beat index; 16 beats per channel (0..15).
  localparam logic [4:0] CALC_LAST = 5'd15;
  // Last channel index; 24 channels per frame (0..23).
  localparam logic [4:0] CH_LAST   = 5'd23;
  // Flops in the single scan chain.
  localparam int         CHAIN_LEN = 20;

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - scan access bundle for the control unit
// Purpose: groups the scan-side signals so an environment can drive the
//          chain through one handle.
// Ports:   scan_in0 (serial data in), scan_en (1 = shift), scan_out0
//          (serial data out). master drives the chain, slave is the block.
interface control_unit_if;
  logic scan_in0;
  logic scan_en;
  logic scan_out0;

  modport master (output scan_in0, output scan_en, input scan_out0);
  modport slave  (input scan_in0, input scan_en, output scan_out0);
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - frame/channel/bit sequencer with full scan chain
// Purpose: IDLE -> LOAD -> 16 x CALC -> STORE sequencer counting channels
//          and frames; all 20 flops form one scan chain.
// Ports:   clk       in  rising-edge clock
//          reset     in  synchronous active-high reset (wins over shift)
//          scan_in0  in  serial scan data in
//          scan_en   in  1 = shift chain, 0 = functional update
//          scan_out0 out last chain flop (state[1])
module control_unit
  import control_unit_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scan_in0,
  input  logic scan_en,
  output logic scan_out0
);

  // Chain layout, MSB first: {state[1:0], bit_cnt[4:0], ch_cnt[4:0], frame_cnt[7:0]}.
  logic [CHAIN_LEN-1:0] chain_q;
  logic [CHAIN_LEN-1:0] chain_d;

  state_e     state_q, state_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [4:0] ch_cnt_q, ch_cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_q     = state_e'(chain_q[19:18]);
    bit_cnt_q   = chain_q[17:13];
    ch_cnt_q    = chain_q[12:8];
    frame_cnt_q = chain_q[7:0];
  end

  // Functional next state; counters hold unless the current state names them.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ch_cnt_d    = ch_cnt_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        state_d   = CALC;
        bit_cnt_d = 5'd0;
      end
      CALC: begin
        // >= rather than == so scan-loaded values above 15 still exit.
        if (bit_cnt_q >= CALC_LAST) begin
          state_d   = STORE;
          bit_cnt_d = 5'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      STORE: begin
        state_d = LOAD;
        if (ch_cnt_q >= CH_LAST) begin
          ch_cnt_d    = 5'd0;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
          ch_cnt_d = ch_cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan mux ahead of every flop: shift path or functional path.
  always_comb begin
    chain_d = {state_d, bit_cnt_d, ch_cnt_d, frame_cnt_d};
    if (scan_en) begin
      chain_d = {chain_q[CHAIN_LEN-2:0], scan_in0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign scan_out0 = chain_q[CHAIN_LEN-1];

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;
  import control_unit_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  control_unit_if cu_if ();

  control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .scan_in0  (cu_if.scan_in0),
    .scan_en   (cu_if.scan_en),
    .scan_out0 (cu_if.scan_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the sequencer as plain named counters.
  logic [1:0] m_state;
  logic [4:0] m_bit;
  logic [4:0] m_ch;
  logic [7:0] m_frame;

  function automatic logic [CHAIN_LEN-1:0] m_pack();
    return {m_state, m_bit, m_ch, m_frame};
  endfunction

  task automatic m_clear();
    m_state = 2'd0; m_bit = 5'd0; m_ch = 5'd0; m_frame = 8'd0;
  endtask

  task automatic m_shift(input logic si);
    logic [CHAIN_LEN-1:0] c;
    c = m_pack();
    c = {c[CHAIN_LEN-2:0], si};
    {m_state, m_bit, m_ch, m_frame} = c;
  endtask

  task automatic m_func();
    case (m_state)
      2'd0: m_state = 2'd1;
      2'd1: begin m_state = 2'd2; m_bit = 5'd0; end
      2'd2: begin
        if (int'(m_bit) >= 15) begin m_state = 2'd3; m_bit = 5'd0; end
        else m_bit = m_bit + 5'd1;
      end
      default: begin
        m_state = 2'd1;
        if (int'(m_ch) >= 23) begin m_ch = 5'd0; m_frame = m_frame + 8'd1; end
        else m_ch = m_ch + 5'd1;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 time unit later.
  task automatic step(input logic rst, input logic en, input logic si);
    @(negedge clk);
    reset          = rst;
    cu_if.scan_en  = en;
    cu_if.scan_in0 = si;
    @(posedge clk);
    if (rst) m_clear();
    else if (en) m_shift(si);
    else m_func();
    #1;
    check("scan_out0", 32'(cu_if.scan_out0), 32'(m_pack() >> (CHAIN_LEN - 1)));
  endtask

  task automatic load(input logic [CHAIN_LEN-1:0] v);
    for (int i = CHAIN_LEN - 1; i >= 0; i--) step(1'b0, 1'b1, v[i]);
  endtask

  task automatic unload(output logic [CHAIN_LEN-1:0] v);
    for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
      v[i] = cu_if.scan_out0;
      step(1'b0, 1'b1, 1'b0);
    end
  endtask

  logic [CHAIN_LEN-1:0] got;
  logic [CHAIN_LEN-1:0] exp_v;

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    cu_if.scan_en  = 1'b0;
    cu_if.scan_in0 = 1'b0;
    m_clear();

    // Reset state, then one functional clock puts LOAD into the chain.
    step(1'b1, 1'b0, 1'b0);
    check("reset_out0", 32'(cu_if.scan_out0), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    unload(got);
    check("first_func_load", 32'(got), 32'h40000);

    // Loopback of a known pattern.
    load(20'hA5C3F);
    unload(got);
    check("loopback", 32'(got), 32'hA5C3F);

    // Channel and frame wrap from STORE, ch=23, frame=255; bit_cnt untouched.
    load({2'd3, 5'd7, 5'd23, 8'hFF});
    step(1'b0, 1'b0, 1'b0);
    unload(got);
    check("store_wrap", 32'(got), 32'({2'd1, 5'd7, 5'd0, 8'h00}));

    // Plain STORE increments ch_cnt only.
    load({2'd3, 5'd4, 5'd9, 8'h20});
    step(1'b0, 1'b0, 1'b0);
    unload(got);
    check("store_inc", 32'(got), 32'({2'd1, 5'd4, 5'd10, 8'h20}));

    // Out-of-range bit_cnt in CALC exits to STORE.
    load({2'd2, 5'd20, 5'd3, 8'h12});
    step(1'b0, 1'b0, 1'b0);
    unload(got);
    check("calc_oor", 32'(got), 32'({2'd3, 5'd0, 5'd3, 8'h12}));

    // CALC at bit 14 keeps counting; at 15 it exits.
    load({2'd2, 5'd14, 5'd1, 8'h05});
    step(1'b0, 1'b0, 1'b0);
    unload(got);
    check("calc_14", 32'(got), 32'({2'd2, 5'd15, 5'd1, 8'h05}));
    load({2'd2, 5'd15, 5'd1, 8'h05});
    step(1'b0, 1'b0, 1'b0);
    unload(got);
    check("calc_15", 32'(got), 32'({2'd3, 5'd0, 5'd1, 8'h05}));

    // One full frame from reset: 1 + 24*18 functional clocks.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 433; i++) step(1'b0, 1'b0, 1'b0);
    unload(got);
    check("frame_period", 32'(got), 32'({2'd1, 5'd0, 5'd0, 8'd1}));

    // Reset beats shift with a full chain.
    load(20'hFFFFF);
    step(1'b1, 1'b1, 1'b1);
    unload(got);
    check("reset_over_shift", 32'(got), 32'd0);

    // Reset mid-operation clears everything on that edge.
    load({2'd2, 5'd9, 5'd17, 8'h77});
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    unload(got);
    check("reset_mid_op", 32'(got), 32'd0);

    // Random mix of shift, functional and occasional reset against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    exp_v = m_pack();
    unload(got);
    check("random_final", 32'(got), 32'(exp_v));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
